// File: rtl/pwm_fader.sv
// pwm_fader: upstream control stage for the pwm block.
// Moves duty_cycle toward a commanded target one step per prescaled tick,
// or sweeps it between 0 and DUTY_MAX in breathing mode when no command runs.
module pwm_fader #(
    parameter int unsigned DUTY_MAX = 100,
    parameter int unsigned STEP_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_target,
    input  logic [7:0] cmd_step,
    input  logic       breathe,
    output logic [7:0] duty_cycle,
    output logic       pwm_start,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP    = 2'd1,
        BR_UP   = 2'd2,
        BR_DOWN = 2'd3
    } state_t;

    localparam logic [7:0]  DUTY_MAX_C   = 8'(DUTY_MAX);
    localparam logic [23:0] PRESC_RELOAD = 24'(STEP_DIV - 1);

    // Saturating increment: min(cur + inc, limit), computed 9-bit so it cannot wrap.
    function automatic logic [7:0] step_up(input logic [7:0] cur,
                                           input logic [7:0] inc,
                                           input logic [7:0] limit);
        logic [8:0] sum;
        sum = {1'b0, cur} + {1'b0, inc};
        if (sum > {1'b0, limit}) begin
            return limit;
        end else begin
            return sum[7:0];
        end
    endfunction

    // Saturating decrement: max(cur - dec, lower), never going below lower.
    function automatic logic [7:0] step_down(input logic [7:0] cur,
                                             input logic [7:0] dec,
                                             input logic [7:0] lower);
        if ({1'b0, cur} < ({1'b0, dec} + {1'b0, lower})) begin
            return lower;
        end else begin
            return cur - dec;
        end
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    logic [7:0]  target_r;
    logic [7:0]  step_r;
    logic [23:0] presc_r;
    logic [23:0] presc_next_s;
    logic [7:0]  duty_next_s;
    logic [7:0]  target_next_s;
    logic [7:0]  step_next_s;
    logic        done_next_s;
    logic        accept_s;
    logic        tick_s;
    logic [7:0]  target_clamped_s;
    logic [7:0]  step_fixed_s;

    assign cmd_ready        = (state_r != RAMP);
    assign accept_s         = cmd_valid && cmd_ready;
    assign tick_s           = (state_r != IDLE) && (presc_r == 24'd0);
    assign target_clamped_s = (cmd_target > DUTY_MAX_C) ? DUTY_MAX_C : cmd_target;
    assign step_fixed_s     = (cmd_step == 8'd0) ? 8'd1 : cmd_step;

    // Next-state and next-duty decision; a new command always takes priority.
    always_comb begin
        next_state_s  = state_r;
        duty_next_s   = duty_cycle;
        target_next_s = target_r;
        step_next_s   = step_r;
        done_next_s   = 1'b0;
        if (accept_s) begin
            target_next_s = target_clamped_s;
            step_next_s   = step_fixed_s;
            if (target_clamped_s == duty_cycle) begin
                next_state_s = IDLE;
                done_next_s  = 1'b1;
            end else begin
                next_state_s = RAMP;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (breathe) begin
                        if (duty_cycle < DUTY_MAX_C) begin
                            next_state_s = BR_UP;
                        end else begin
                            next_state_s = BR_DOWN;
                        end
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                RAMP: begin
                    if (tick_s) begin
                        if (duty_cycle < target_r) begin
                            duty_next_s = step_up(duty_cycle, step_r, target_r);
                        end else begin
                            duty_next_s = step_down(duty_cycle, step_r, target_r);
                        end
                        if (duty_next_s == target_r) begin
                            next_state_s = IDLE;
                            done_next_s  = 1'b1;
                        end else begin
                            next_state_s = RAMP;
                        end
                    end else begin
                        next_state_s = RAMP;
                    end
                end
                BR_UP: begin
                    if (!breathe) begin
                        next_state_s = IDLE;
                    end else if (tick_s) begin
                        duty_next_s = step_up(duty_cycle, step_r, DUTY_MAX_C);
                        if (duty_next_s == DUTY_MAX_C) begin
                            next_state_s = BR_DOWN;
                        end else begin
                            next_state_s = BR_UP;
                        end
                    end else begin
                        next_state_s = BR_UP;
                    end
                end
                BR_DOWN: begin
                    if (!breathe) begin
                        next_state_s = IDLE;
                    end else if (tick_s) begin
                        duty_next_s = step_down(duty_cycle, step_r, 8'd0);
                        if (duty_next_s == 8'd0) begin
                            next_state_s = BR_UP;
                        end else begin
                            next_state_s = BR_DOWN;
                        end
                    end else begin
                        next_state_s = BR_DOWN;
                    end
                end
                default: begin
                    next_state_s = IDLE;
                end
            endcase
        end
    end

    // Prescaler reload/decrement: it only counts while a ramp or sweep is running.
    always_comb begin
        if (accept_s || tick_s || (state_r == IDLE) || (next_state_s == IDLE)) begin
            presc_next_s = PRESC_RELOAD;
        end else begin
            presc_next_s = presc_r - 24'd1;
        end
    end

    // State, datapath and registered outputs with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            duty_cycle <= 8'd0;
            target_r   <= 8'd0;
            step_r     <= 8'd1;
            presc_r    <= PRESC_RELOAD;
            pwm_start  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            duty_cycle <= duty_next_s;
            target_r   <= target_next_s;
            step_r     <= step_next_s;
            presc_r    <= presc_next_s;
            pwm_start  <= (next_state_s != IDLE) || (duty_next_s != 8'd0);
            busy       <= (next_state_s != IDLE);
            done       <= done_next_s;
        end
    end

endmodule

// File: tb/tb_pwm_fader.sv
// Self-checking bench for pwm_fader with STEP_DIV=4 and a behavioural model.
module tb_pwm_fader;

    localparam int SD   = 4;
    localparam int DMAX = 100;
    localparam int M_IDLE = 0;
    localparam int M_RAMP = 1;
    localparam int M_UP   = 2;
    localparam int M_DOWN = 3;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_target;
    logic [7:0] cmd_step;
    logic       breathe;
    logic [7:0] duty_cycle;
    logic       pwm_start;
    logic       busy;
    logic       done;

    int vectors;
    int miscompares;

    // behavioural model state
    int m_mode;
    int m_duty;
    int m_target;
    int m_step;
    int m_wait;     // clock edges left until the next tick while active
    int m_done;
    int m_accepts;

    int acc0;
    int hits;
    bit found;
    bit r_v;
    int r_t;
    int r_s;
    bit br_lvl;

    pwm_fader #(.DUTY_MAX(100), .STEP_DIV(SD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_target(cmd_target),
        .cmd_step  (cmd_step),
        .breathe   (breathe),
        .duty_cycle(duty_cycle),
        .pwm_start (pwm_start),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("duty_cycle", {24'd0, duty_cycle}, m_duty);
        check("pwm_start", {31'd0, pwm_start}, ((m_mode != M_IDLE) || (m_duty != 0)) ? 1 : 0);
        check("busy", {31'd0, busy}, (m_mode != M_IDLE) ? 1 : 0);
        check("done", {31'd0, done}, m_done);
        check("cmd_ready", {31'd0, cmd_ready}, (m_mode != M_RAMP) ? 1 : 0);
    endtask

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_duty   = 0;
        m_target = 0;
        m_step   = 1;
        m_wait   = SD;
        m_done   = 0;
    endtask

    // One clock edge of the fader, from the rules: command first, then breathing/ramping.
    task automatic model_edge(input bit v, input int t, input int s, input bit b);
        m_done = 0;
        if (v && (m_mode != M_RAMP)) begin
            m_accepts++;
            m_target = (t > DMAX) ? DMAX : t;
            m_step   = (s == 0) ? 1 : s;
            m_wait   = SD;
            if (m_target == m_duty) begin
                m_mode = M_IDLE;
                m_done = 1;
            end else begin
                m_mode = M_RAMP;
            end
        end else if (m_mode == M_IDLE) begin
            if (b) m_mode = (m_duty < DMAX) ? M_UP : M_DOWN;
        end else if ((m_mode != M_RAMP) && !b) begin
            m_mode = M_IDLE;
            m_wait = SD;
        end else begin
            m_wait--;
            if (m_wait == 0) begin
                m_wait = SD;
                if (m_mode == M_RAMP) begin
                    if (m_duty < m_target) begin
                        m_duty = (m_duty + m_step > m_target) ? m_target : m_duty + m_step;
                    end else begin
                        m_duty = (m_duty - m_step < m_target) ? m_target : m_duty - m_step;
                    end
                    if (m_duty == m_target) begin
                        m_mode = M_IDLE;
                        m_done = 1;
                    end
                end else if (m_mode == M_UP) begin
                    m_duty = (m_duty + m_step > DMAX) ? DMAX : m_duty + m_step;
                    if (m_duty == DMAX) m_mode = M_DOWN;
                end else begin
                    m_duty = (m_duty - m_step < 0) ? 0 : m_duty - m_step;
                    if (m_duty == 0) m_mode = M_UP;
                end
            end
        end
    endtask

    task automatic cycle(input bit v, input int t, input int s, input bit b);
        cmd_valid  = v;
        cmd_target = 8'(t);
        cmd_step   = 8'(s);
        breathe    = b;
        model_edge(v, t, s, b);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_cycles(input int n, input bit b);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, b);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_accepts   = 0;
        br_lvl      = 1'b0;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_target  = 8'd0;
        cmd_step    = 8'd0;
        breathe     = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // basic ramp 0 -> 50 in steps of 10
        cycle(1'b1, 50, 10, 1'b0);
        idle_cycles(24, 1'b0);

        // clamp and no overshoot: 50 -> 95, then target 200 -> 100
        cycle(1'b1, 95, 45, 1'b0);
        idle_cycles(6, 1'b0);
        cycle(1'b1, 200, 10, 1'b0);
        idle_cycles(6, 1'b0);
        // down to 7, then 7 -> 2 -> 0 with step 5
        cycle(1'b1, 7, 93, 1'b0);
        idle_cycles(6, 1'b0);
        cycle(1'b1, 0, 5, 1'b0);
        idle_cycles(10, 1'b0);

        // zero step behaves as 1, then equal target gives an immediate done
        cycle(1'b1, 3, 0, 1'b0);
        idle_cycles(14, 1'b0);
        cycle(1'b1, 3, 9, 1'b0);
        idle_cycles(3, 1'b0);

        // set step_reg=50 at duty 0, then breathe through 50,100,50,0,50,100
        cycle(1'b1, 0, 50, 1'b0);
        idle_cycles(6, 1'b0);
        hits  = 0;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cycle(1'b0, 0, 0, 1'b1);
            if (m_duty == DMAX && m_wait == SD) hits++;
            if (hits == 2) begin
                found = 1'b1;
                break;
            end
        end
        check("breathe_reach_max_twice", {31'd0, found}, 1);
        // command while sweeping at 100 aborts breathing
        cycle(1'b1, 20, 50, 1'b1);
        idle_cycles(14, 1'b0);

        // async reset in the middle of a ramp, between clock edges
        cycle(1'b1, 90, 10, 1'b0);
        idle_cycles(6, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(6, 1'b0);

        // handshake hold-off: valid held through the ramp, accepted once more at IDLE
        acc0 = m_accepts;
        cycle(1'b1, 60, 20, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 10, 30, 1'b0);
            if (m_accepts == acc0 + 2) begin
                found = 1'b1;
                break;
            end
        end
        check("holdoff_second_accept", {31'd0, found}, 1);
        idle_cycles(12, 1'b0);

        // randomized commands and breathe toggling
        for (int i = 0; i < 600; i++) begin
            r_v = ($urandom_range(0, 7) == 0);
            r_t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(101, 255)) : int'($urandom_range(0, 100));
            r_s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 30));
            if ($urandom_range(0, 39) == 0) br_lvl = ~br_lvl;
            cycle(r_v, r_t, r_s, br_lvl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
